// File: rtl/systolic_feed_controller.sv
// systolic_feed_controller
// Sequences the RAM loader and the DEPTH x DEPTH brightness systolic array.
// Each loader block is captured once, fed into the array one lane per cycle
// (lane i on feed cycle i), allowed to drain through the array latency, and
// then the loader is handed a single tpu_ready pulse for the next block.
// The pass ends after NUM_BLOCKS blocks, or early once the loader reports
// ld_done, with a one-cycle done pulse.

module systolic_feed_controller #(
  parameter int PE_DATA_WIDTH = 16,
  parameter int DEPTH         = 4,
  parameter int NUM_BLOCKS    = 16,
  parameter int ARRAY_LATENCY = 7,
  localparam int CNT_W        = $clog2(NUM_BLOCKS + 1),
  localparam int BUS_W        = PE_DATA_WIDTH * DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [7:0]               brightness,
  input  logic [BUS_W-1:0]         ld_data,
  input  logic                     ld_valid,
  input  logic                     ld_load_next,
  input  logic                     ld_done,
  output logic                     ld_start,
  output logic                     tpu_ready,
  output logic [BUS_W-1:0]         arr_data,
  output logic [DEPTH-1:0]         arr_valid,
  output logic [PE_DATA_WIDTH-1:0] arr_bias,
  output logic [CNT_W-1:0]         block_count,
  output logic                     busy,
  output logic                     overrun,
  output logic                     done
);

  localparam int FEED_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DRAIN_W = $clog2(ARRAY_LATENCY + 1);

  localparam logic [FEED_W-1:0]  FEED_LAST  = FEED_W'(DEPTH - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(ARRAY_LATENCY - 1);
  localparam logic [CNT_W-1:0]   BLK_LAST   = CNT_W'(NUM_BLOCKS - 1);
  localparam logic [CNT_W-1:0]   BLK_MAX    = CNT_W'(NUM_BLOCKS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_DATA,
    S_FEED,
    S_DRAIN,
    S_HANDSHAKE,
    S_DONE
  } state_t;

  state_t             state;
  logic [BUS_W-1:0]   blk_reg;       // block captured for the current feed
  logic [FEED_W-1:0]  feed_cnt;      // lane currently presented to the array
  logic [DRAIN_W-1:0] drain_cnt;     // cycles spent waiting out array latency
  logic               ld_done_seen;  // loader has reported its last block
  logic               ld_valid_q;    // previous ld_valid, for edge detection

  logic [FEED_W-1:0]  next_lane;
  logic [BUS_W-1:0]   next_lane_data;
  logic [DEPTH-1:0]   next_lane_valid;
  logic               ld_valid_rise;
  logic               pass_ends;

  // Next skewed lane: only lane feed_cnt+1 carries data, all others are zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    next_lane       = feed_cnt + FEED_W'(1);
    next_lane_data  = '0;
    next_lane_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (next_lane == FEED_W'(i)) begin
        next_lane_data[i*PE_DATA_WIDTH +: PE_DATA_WIDTH] = blk_reg[i*PE_DATA_WIDTH +: PE_DATA_WIDTH];
        next_lane_valid[i] = 1'b1;
      end
    end
    ld_valid_rise = ld_valid & ~ld_valid_q;
    // ld_done in the final drain cycle still ends the pass, as the sticky bit
    // would only become visible one edge too late.
    pass_ends     = ld_done_seen | ld_done | (block_count >= BLK_LAST);
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (reset) begin
      state        <= S_IDLE;
      // NOTE: blk_reg is a plain register, not a memory array, so it is cleared with everything else.
      blk_reg      <= '0;
      feed_cnt     <= '0;
      drain_cnt    <= '0;
      ld_done_seen <= 1'b0;
      ld_valid_q   <= 1'b0;
      ld_start     <= 1'b0;
      tpu_ready    <= 1'b0;
      arr_data     <= '0;
      arr_valid    <= '0;
      arr_bias     <= '0;
      block_count  <= '0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      done         <= 1'b0;
    end else begin
      // Pulse outputs drop unless a state below re-asserts them.
      ld_start   <= 1'b0;
      tpu_ready  <= 1'b0;
      done       <= 1'b0;
      ld_valid_q <= ld_valid;

      if (busy && ld_done) begin
        ld_done_seen <= 1'b1;
      end

      // A fresh block arriving while the array is occupied is dropped and flagged.
      if ((state == S_FEED || state == S_DRAIN) && ld_valid_rise) begin
        overrun <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_ARM;
            ld_start     <= 1'b1;
            busy         <= 1'b1;
            arr_bias     <= PE_DATA_WIDTH'(brightness);
            block_count  <= '0;
            overrun      <= 1'b0;
            ld_done_seen <= 1'b0;
          end
        end

        S_ARM: begin
          state <= S_WAIT_DATA;
        end

        S_WAIT_DATA: begin
          // Lane 0 goes out straight from ld_data so it appears the cycle after capture.
          if (ld_valid) begin
            blk_reg   <= ld_data;
            feed_cnt  <= '0;
            arr_valid <= DEPTH'(1);
            arr_data  <= BUS_W'(ld_data[PE_DATA_WIDTH-1:0]);
            state     <= S_FEED;
          end
        end

        S_FEED: begin
          if (feed_cnt == FEED_LAST) begin
            arr_valid <= '0;
            arr_data  <= '0;
            drain_cnt <= '0;
            state     <= S_DRAIN;
          end else begin
            feed_cnt  <= next_lane;
            arr_valid <= next_lane_valid;
            arr_data  <= next_lane_data;
          end
        end

        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            if (block_count != BLK_MAX) begin
              block_count <= block_count + CNT_W'(1);
            end
            if (pass_ends) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_HANDSHAKE;
            end
          end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
          end
        end

        S_HANDSHAKE: begin
          if (ld_load_next) begin
            tpu_ready <= 1'b1;
            state     <= S_WAIT_DATA;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
